pipe_hazard_ctrl: RTL and testbench

Pipeline hazard and sequencing controller for the 5-stage MIPS core. Drives the `en`/`flush` inputs of the IF/ID, ID/EX and EX/MEM pipeline registers, and the PC write enable. It performs four functions:
- a power-up flush sequence;
- load-use stalls;
- branch/jump squashes;
- multi-cycle multiply/divide (MDU) waits.

It also exports a saturating stall-cycle counter for performance debug.

---
 rtl/pipe_hazard_ctrl.sv | 132 +++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/pipe_hazard_ctrl.sv
// Hazard/sequencing controller for the 5-stage MIPS pipeline: power-up flush,
// load-use stalls, branch/jump squashes and MDU waits, plus a stall-cycle counter.
module pipe_hazard_ctrl #(
    parameter int START_FLUSH_CYCLES = 3,
    parameter int REG_ADDR_W         = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  IDEX_DMemRead_in,
    input  logic [REG_ADDR_W-1:0] IDEX_Rt_in,
    input  logic [REG_ADDR_W-1:0] IFID_Rs_in,
    input  logic [REG_ADDR_W-1:0] IFID_Rt_in,
    input  logic                  IFID_UsesRt_in,
    input  logic                  BranchTaken_in,
    input  logic                  JumpID_in,
    input  logic                  MduStart_in,
    input  logic                  MduDone_in,
    output logic                  PCWrite_out,
    output logic                  IFID_en_out,
    output logic                  IFID_flush_out,
    output logic                  IDEX_en_out,
    output logic                  IDEX_flush_out,
    output logic                  EXMEM_flush_out,
    output logic [15:0]           StallCount_out
);

    typedef enum logic [1:0] {
        INIT     = 2'd0,
        RUN      = 2'd1,
        MDU_WAIT = 2'd2
    } state_t;

    state_t      state;
    state_t      nextState;
    logic [3:0]  initCnt;
    logic [15:0] stallCount;
    logic        loadUse;

    assign loadUse = IDEX_DMemRead_in && (IDEX_Rt_in != {REG_ADDR_W{1'b0}}) &&
                     ((IDEX_Rt_in == IFID_Rs_in) ||
                      (IFID_UsesRt_in && (IDEX_Rt_in == IFID_Rt_in)));

    // Control outputs and next state; the default set is the flushing INIT set.
    always_comb begin
        PCWrite_out     = 1'b0;
        IFID_en_out     = 1'b1;
        IDEX_en_out     = 1'b1;
        IFID_flush_out  = 1'b1;
        IDEX_flush_out  = 1'b1;
        EXMEM_flush_out = 1'b1;
        nextState       = state;
        case (state)
            INIT: begin
                if (initCnt == 4'd1) begin
                    nextState = RUN;
                end else begin
                    nextState = INIT;
                end
            end
            RUN: begin
                PCWrite_out     = 1'b1;
                IFID_flush_out  = 1'b0;
                IDEX_flush_out  = 1'b0;
                EXMEM_flush_out = 1'b0;
                nextState       = RUN;
                if (BranchTaken_in) begin
                    IFID_flush_out = 1'b1;
                    IDEX_flush_out = 1'b1;
                end else if (MduStart_in && !MduDone_in) begin
                    PCWrite_out     = 1'b0;
                    IFID_en_out     = 1'b0;
                    IDEX_en_out     = 1'b0;
                    EXMEM_flush_out = 1'b1;
                    nextState       = MDU_WAIT;
                end else if (loadUse) begin
                    PCWrite_out    = 1'b0;
                    IFID_en_out    = 1'b0;
                    IDEX_flush_out = 1'b1;
                end else if (JumpID_in) begin
                    IFID_flush_out = 1'b1;
                end else begin
                    nextState = RUN;
                end
            end
            MDU_WAIT: begin
                IFID_flush_out = 1'b0;
                IDEX_flush_out = 1'b0;
                if (MduDone_in) begin
                    PCWrite_out     = 1'b1;
                    EXMEM_flush_out = 1'b0;
                    nextState       = RUN;
                end else begin
                    IFID_en_out = 1'b0;
                    IDEX_en_out = 1'b0;
                    nextState   = MDU_WAIT;
                end
            end
            default: begin
                nextState = INIT;
            end
        endcase
    end

    // State register and power-up flush counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= INIT;
            initCnt <= 4'(START_FLUSH_CYCLES);
        end else begin
            state <= nextState;
            if (state == INIT) begin
                initCnt <= initCnt - 4'd1;
            end else begin
                initCnt <= initCnt;
            end
        end
    end

    // Saturating count of cycles the PC was held outside the power-up flush.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stallCount <= 16'd0;
        end else if (!PCWrite_out && (state != INIT) && (stallCount != 16'hFFFF)) begin
            stallCount <= stallCount + 16'd1;
        end else begin
            stallCount <= stallCount;
        end
    end

    assign StallCount_out = stallCount;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: an abstract per-cycle model checked on
// every falling edge, plus literal expectations at key points of the sequence.
module tb_pipe_hazard_ctrl;
    localparam int START = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       dMemRead = 1'b0;
    logic [4:0] exRt = 5'd0;
    logic [4:0] idRs = 5'd0;
    logic [4:0] idRt = 5'd0;
    logic       usesRt = 1'b0;
    logic       branch = 1'b0;
    logic       jump = 1'b0;
    logic       mduStart = 1'b0;
    logic       mduDone = 1'b0;
    logic       pcWrite, ifidEn, ifidFlush, idexEn, idexFlush, exmemFlush;
    logic [15:0] stallCount;

    int checks = 0;
    int passed = 0;

    // Abstract model: flush edges left, waiting on MDU, stalls seen so far.
    int mInitLeft = START;
    bit mInMdu    = 1'b0;
    int mStalls   = 0;

    pipe_hazard_ctrl #(.START_FLUSH_CYCLES(START), .REG_ADDR_W(5)) dut (
        .clk(clk), .rst(rst),
        .IDEX_DMemRead_in(dMemRead), .IDEX_Rt_in(exRt),
        .IFID_Rs_in(idRs), .IFID_Rt_in(idRt), .IFID_UsesRt_in(usesRt),
        .BranchTaken_in(branch), .JumpID_in(jump),
        .MduStart_in(mduStart), .MduDone_in(mduDone),
        .PCWrite_out(pcWrite), .IFID_en_out(ifidEn), .IFID_flush_out(ifidFlush),
        .IDEX_en_out(idexEn), .IDEX_flush_out(idexFlush),
        .EXMEM_flush_out(exmemFlush), .StallCount_out(stallCount)
    );

    always #5 clk = ~clk;

    function automatic bit hazard();
        return dMemRead && exRt != 5'd0 &&
               (exRt == idRs || (usesRt && exRt == idRt));
    endfunction

    // Expected {PCWrite, IFID_en, IFID_flush, IDEX_en, IDEX_flush, EXMEM_flush}.
    function automatic logic [5:0] expectCtl();
        if (rst || mInitLeft > 0) return 6'b0_1_1_1_1_1;
        if (mInMdu) return mduDone ? 6'b1_1_0_1_0_0 : 6'b0_0_0_0_0_1;
        if (branch) return 6'b1_1_1_1_1_0;
        if (mduStart && !mduDone) return 6'b0_0_0_0_0_1;
        if (hazard()) return 6'b0_0_0_1_1_0;
        if (jump) return 6'b1_1_1_1_0_0;
        return 6'b1_1_0_1_0_0;
    endfunction

    task automatic checkVal(input string name, input int actual, input int expected);
        checks++;
        if (actual == expected) passed++;
        else $display("FAIL %s: got %0d expected %0d", name, actual, expected);
    endtask

    // Per-cycle compare against the model while inputs are stable.
    always @(negedge clk) begin
        logic [5:0] ctl;
        int         expCount;
        ctl      = {pcWrite, ifidEn, ifidFlush, idexEn, idexFlush, exmemFlush};
        expCount = rst ? 0 : (mStalls > 65535 ? 65535 : mStalls);
        checks++;
        if (ctl == expectCtl() && int'(stallCount) == expCount) passed++;
        else $display("FAIL cycle@%0t: ctl=%b count=%0d expected ctl=%b count=%0d",
                      $time, ctl, stallCount, expectCtl(), expCount);
    end

    // Advance the model on each rising edge.
    always @(posedge clk) begin
        logic [5:0] ctl;
        ctl = expectCtl();
        if (rst) begin
            mInitLeft = START;
            mInMdu    = 1'b0;
            mStalls   = 0;
        end else if (mInitLeft > 0) begin
            mInitLeft--;
        end else begin
            if (!ctl[5]) mStalls++;
            if (mInMdu) mInMdu = !mduDone;
            else        mInMdu = !branch && mduStart && !mduDone;
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clearIn();
        dMemRead = 1'b0; exRt = 5'd0; idRs = 5'd0; idRt = 5'd0; usesRt = 1'b0;
        branch = 1'b0; jump = 1'b0; mduStart = 1'b0; mduDone = 1'b0;
    endtask

    initial begin
        clearIn();
        step(2);
        checkVal("reset_pcwrite", pcWrite, 0);
        checkVal("reset_exmem_flush", exmemFlush, 1);
        rst = 1'b0;
        #1;
        checkVal("init_pcwrite", pcWrite, 0);
        step(2);
        checkVal("init_last_flush", ifidFlush, 1);
        step(1);
        checkVal("run_pcwrite", pcWrite, 1);
        checkVal("run_ifid_flush", ifidFlush, 0);
        checkVal("run_count", stallCount, 0);

        // Load-use on rs.
        dMemRead = 1'b1; exRt = 5'd8; idRs = 5'd8; #1;
        checkVal("lu_pcwrite", pcWrite, 0);
        checkVal("lu_ifid_en", ifidEn, 0);
        checkVal("lu_idex_flush", idexFlush, 1);
        step(1); clearIn(); #1;
        checkVal("lu_count", stallCount, 1);
        checkVal("lu_release", pcWrite, 1);
        // Load to $zero never stalls.
        dMemRead = 1'b1; exRt = 5'd0; idRs = 5'd0; #1;
        checkVal("lu_zero", pcWrite, 1);
        // rt match ignored unless the ID instruction reads rt.
        exRt = 5'd9; idRs = 5'd3; idRt = 5'd9; usesRt = 1'b0; #1;
        checkVal("lu_rt_unused", pcWrite, 1);
        usesRt = 1'b1; #1;
        checkVal("lu_rt_used", pcWrite, 0);
        step(1); clearIn(); #1;
        checkVal("lu_rt_count", stallCount, 2);

        // Branch outranks load-use and jump.
        dMemRead = 1'b1; exRt = 5'd8; idRs = 5'd8; jump = 1'b1; branch = 1'b1; #1;
        checkVal("br_ifid_flush", ifidFlush, 1);
        checkVal("br_idex_flush", idexFlush, 1);
        checkVal("br_pcwrite", pcWrite, 1);
        checkVal("br_ifid_en", ifidEn, 1);
        step(1); clearIn();
        jump = 1'b1; #1;
        checkVal("jmp_ifid_flush", ifidFlush, 1);
        checkVal("jmp_idex_flush", idexFlush, 0);
        step(1); clearIn(); #1;
        checkVal("br_jmp_count", stallCount, 2);

        // MDU: start, done five cycles later; branch during the wait is ignored.
        mduStart = 1'b1;
        step(1); mduStart = 1'b0;
        step(1); branch = 1'b1; #1;
        checkVal("mdu_idex_en", idexEn, 0);
        checkVal("mdu_exmem_flush", exmemFlush, 1);
        checkVal("mdu_branch_ignored", ifidFlush, 0);
        step(1); branch = 1'b0;
        step(2); mduDone = 1'b1; #1;
        checkVal("mdu_done_pcwrite", pcWrite, 1);
        checkVal("mdu_done_exmem", exmemFlush, 0);
        step(1); clearIn(); #1;
        checkVal("mdu_count", stallCount, 7);
        mduStart = 1'b1; mduDone = 1'b1; #1;
        checkVal("mdu_same_cycle", pcWrite, 1);
        step(1); clearIn(); step(1);
        checkVal("mdu_same_count", stallCount, 7);

        // Reset in the middle of an MDU wait.
        mduStart = 1'b1;
        step(1); mduStart = 1'b0;
        step(1);
        checkVal("mid_count_before", stallCount, 9);
        rst = 1'b1; #1;
        checkVal("mid_rst_count", stallCount, 0);
        checkVal("mid_rst_ifid_flush", ifidFlush, 1);
        checkVal("mid_rst_ifid_en", ifidEn, 1);
        step(1); rst = 1'b0;
        step(2);
        checkVal("mid_init_pcwrite", pcWrite, 0);
        step(1);
        checkVal("mid_run_pcwrite", pcWrite, 1);

        // Saturation through a very long MDU wait.
        mduStart = 1'b1;
        step(1); mduStart = 1'b0;
        step(69999);
        checkVal("sat_count", stallCount, 65535);
        checkVal("sat_pcwrite", pcWrite, 0);
        mduDone = 1'b1;
        step(1); clearIn(); step(1);
        checkVal("sat_hold", stallCount, 65535);
        checkVal("sat_release", pcWrite, 1);

        @(negedge clk);
        #1;
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
